// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and seed guard for the LFSR stream generator.
package lfsr_pkg;
  typedef enum logic {FIBONACCI, GALOIS} lfsr_mode_e;
  typedef enum logic {S_IDLE, S_VALID} fsm_state_e;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] zero_guard(input logic [MAX_W-1:0] seed);
    return (seed == '0) ? MAX_W'(1) : seed;
  endfunction
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational LFSR step in Fibonacci or Galois form.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int              W    = 8,
  parameter logic [W-1:0]    TAPS = 'hB8,
  parameter lfsr_mode_e      MODE = FIBONACCI
) (
  input  logic [W-1:0] state_i,
  output logic [W-1:0] state_o
);
  always_comb
    state_o = (MODE == GALOIS) ? ((state_i >> 1) ^ (state_i[0] ? TAPS : '0))
                               : {state_i[W-2:0], ^(state_i & TAPS)};
endmodule

// File: rtl/axis_lfsr_stream_gen.sv
// axis_lfsr_stream_gen: pseudo-random AXI4-Stream source with backpressure,
// runtime reseed/enable and TLAST framing.
module axis_lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [LFSR_WIDTH-1:0] TAPS           = 8'hB8,
  parameter logic [LFSR_WIDTH-1:0] SEED           = 8'h3F,
  parameter lfsr_mode_e            MODE           = FIBONACCI,
  parameter int                    STEPS_PER_BEAT = 1,
  parameter int                    PACKET_LEN     = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  seed_valid,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tlast,
  output logic                  busy,
  output logic [31:0]           beat_count
);
  localparam int PW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [PW-1:0] PKT_LAST = PW'(PACKET_LEN - 1);
  localparam logic [LFSR_WIDTH-1:0] SEED_G = LFSR_WIDTH'(zero_guard(MAX_W'(SEED)));

  if (DATA_WIDTH < 1 || DATA_WIDTH > LFSR_WIDTH || LFSR_WIDTH < 2 || LFSR_WIDTH > MAX_W ||
      STEPS_PER_BEAT < 1 || STEPS_PER_BEAT > LFSR_WIDTH || PACKET_LEN < 1) begin : g_bad_params
    $fatal(1, "axis_lfsr_stream_gen: illegal parameter combination");
  end

  fsm_state_e            fsm_q, fsm_d;
  logic [LFSR_WIDTH-1:0] state_q, state_d, pend_q, pend_d;
  logic                  busy_q, busy_d, tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [PW-1:0]         pkt_cnt_q, pkt_cnt_d;
  logic [31:0]           beat_q, beat_d;
  logic                  hs, pend_any, apply;
  logic [LFSR_WIDTH-1:0] pend_val, stepped;

  for (genvar i = 0; i < STEPS_PER_BEAT; i++) begin : g_step
    logic [LFSR_WIDTH-1:0] cur, nxt;
    if (i == 0) begin : g_first
      assign cur = state_q;
    end else begin : g_chain
      assign cur = g_step[i-1].nxt;
    end
    lfsr_step #(.W(LFSR_WIDTH), .TAPS(TAPS), .MODE(MODE)) u_step (.state_i(cur), .state_o(nxt));
  end
  assign stepped = g_step[STEPS_PER_BEAT-1].nxt;

  // A seed arriving this cycle counts as pending, so an idle generator applies it at once
  // and a handshake cycle swaps it in place of the advanced state.
  always_comb begin
    hs        = tvalid_q & out_tready;
    pend_any  = busy_q | seed_valid;
    pend_val  = seed_valid ? seed_in : pend_q;
    apply     = pend_any & ((fsm_q == S_IDLE) | hs);
    state_d   = apply ? LFSR_WIDTH'(zero_guard(MAX_W'(pend_val))) : hs ? stepped : state_q;
    pkt_cnt_d = apply ? '0 : hs ? ((pkt_cnt_q == PKT_LAST) ? '0 : pkt_cnt_q + 1'b1) : pkt_cnt_q;
    beat_d    = apply ? '0 : hs ? beat_q + 32'd1 : beat_q;
    pend_d    = pend_val;
    busy_d    = pend_any & ~apply;
    fsm_d     = (fsm_q == S_IDLE) ? (enable ? S_VALID : S_IDLE)
                                  : ((hs & ~enable) ? S_IDLE : S_VALID);
    tvalid_d  = (fsm_d == S_VALID);
    tlast_d   = (pkt_cnt_d == PKT_LAST);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q     <= S_IDLE;
      state_q   <= SEED_G;
      pend_q    <= '0;
      busy_q    <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      pkt_cnt_q <= '0;
      beat_q    <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      pkt_cnt_q <= pkt_cnt_d;
      beat_q    <= beat_d;
    end
  end

  assign out_tvalid = tvalid_q;
  assign out_tdata  = state_q[DATA_WIDTH-1:0];
  assign out_tlast  = tlast_q;
  assign busy       = busy_q;
  assign beat_count = beat_q;
endmodule

// File: tb/tb_axis_lfsr_stream_gen.sv
// tb_axis_lfsr_stream_gen: directed bench over default, Galois and 16-bit/8-step generators.
module tb_axis_lfsr_stream_gen;
  import lfsr_pkg::*;
  logic clk = 0, resetn = 0, enable = 1;
  always #5 clk = ~clk;
  logic rdy_a = 0, rdy_b = 1, rdy_c = 0, sv_a = 0, sv_n = 0;
  logic [7:0] si_a = 0, si8 = 0;
  logic [15:0] si16 = 0;
  logic va, la, busy_a, vb, lb, busy_b, vc, lc, busy_c;
  logic [7:0] da, db, dc;
  logic [31:0] bc_a, bc_b, bc_c;
  int errs = 0, checks = 0;

  axis_lfsr_stream_gen dut_a (
    .clk(clk), .resetn(resetn), .enable(enable), .seed_valid(sv_a), .seed_in(si_a),
    .out_tvalid(va), .out_tready(rdy_a), .out_tdata(da), .out_tlast(la),
    .busy(busy_a), .beat_count(bc_a));
  axis_lfsr_stream_gen #(.MODE(GALOIS), .SEED(8'h01), .PACKET_LEN(4)) dut_b (
    .clk(clk), .resetn(resetn), .enable(enable), .seed_valid(sv_n), .seed_in(si8),
    .out_tvalid(vb), .out_tready(rdy_b), .out_tdata(db), .out_tlast(lb),
    .busy(busy_b), .beat_count(bc_b));
  axis_lfsr_stream_gen #(.LFSR_WIDTH(16), .DATA_WIDTH(8), .TAPS(16'hB400), .SEED(16'hACE1),
                         .STEPS_PER_BEAT(8)) dut_c (
    .clk(clk), .resetn(resetn), .enable(enable), .seed_valid(sv_n), .seed_in(si16),
    .out_tvalid(vc), .out_tready(rdy_c), .out_tdata(dc), .out_tlast(lc),
    .busy(busy_c), .beat_count(bc_c));

  function automatic logic [7:0] fib8(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction
  function automatic logic [15:0] fib16x8(input logic [15:0] s);
    for (int i = 0; i < 8; i++) s = {s[14:0], ^(s & 16'hB400)};
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid;
    for (int n = 0; n < 4 && !va; n++) tick();
  endtask

  typedef struct {
    logic        rdy;
    logic [7:0]  d;
    logic [31:0] cnt;
    logic [7:0]  db;
    logic        lb;
  } vec_t;
  vec_t tbl [0:10];

  logic [7:0]  ma;
  logic [15:0] mc;
  int          beat;
  logic        hs;

  initial begin
    tbl = '{
      '{1'b1, 8'h3F, 32'd0, 8'h01, 1'b0}, '{1'b0, 8'h3F, 32'd0, 8'hB8, 1'b0},
      '{1'b0, 8'h3F, 32'd0, 8'h5C, 1'b0}, '{1'b1, 8'h7F, 32'd1, 8'h2E, 1'b1},
      '{1'b1, 8'hFF, 32'd2, 8'h17, 1'b0}, '{1'b0, 8'hFF, 32'd2, 8'hB3, 1'b0},
      '{1'b1, 8'hFE, 32'd3, 8'hE1, 1'b0}, '{1'b1, 8'hFC, 32'd4, 8'hC8, 1'b1},
      '{1'b1, 8'hF8, 32'd5, 8'h64, 1'b0}, '{1'b1, 8'hF0, 32'd6, 8'h32, 1'b0},
      '{1'b1, 8'hE1, 32'd7, 8'h19, 1'b0}};
    tick(); tick();
    chk("rst_tvalid", va, 0);
    chk("rst_tlast", la, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_beat_count", bc_a, 0);
    chk("rst_tdata", da, 8'h3F);
    chk("rst_tvalid_b", vb, 0);
    chk("rst_tvalid_c", vc, 0);
    @(negedge clk);
    resetn = 1;
    for (int i = 0; i <= 10; i++) begin
      rdy_a = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_tvalid", i), va, 1);
      chk($sformatf("vec%0d_tdata", i), da, tbl[i].d);
      chk($sformatf("vec%0d_beat_count", i), bc_a, tbl[i].cnt);
      chk($sformatf("vec%0d_tlast", i), la, 0);
      chk($sformatf("vec%0d_galois_tdata", i), db, tbl[i].db);
      chk($sformatf("vec%0d_galois_tlast", i), lb, tbl[i].lb);
    end
    ma = 8'hE1;
    beat = 8;
    for (int n = 0; n < 3000 && beat < 256; n++) begin
      rdy_a = (beat < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = rdy_a;
      tick();
      if (hs) begin
        ma = fib8(ma);
        beat++;
      end
      chk($sformatf("run_tvalid_b%0d", beat), va, 1);
      chk($sformatf("run_tdata_b%0d", beat), da, ma);
      chk($sformatf("run_tlast_b%0d", beat), la, 32'((beat % 16) == 0));
      chk($sformatf("run_beat_count_b%0d", beat), bc_a, beat - 1);
    end
    chk("reached_beat256", beat, 256);
    chk("period_255", da, 8'h3F);
    for (int n = 0; n < 20 && beat < 261; n++) begin
      tick();
      ma = fib8(ma);
      beat++;
    end
    chk("beat261_tdata", da, ma);
    rdy_a = 0; sv_a = 1; si_a = 8'h01;
    tick();
    sv_a = 0;
    chk("reseed_busy", busy_a, 1);
    chk("reseed_stall_tdata", da, ma);
    chk("reseed_stall_tvalid", va, 1);
    chk("reseed_stall_count", bc_a, 260);
    tick();
    chk("reseed_busy_hold", busy_a, 1);
    chk("reseed_stall_tdata2", da, ma);
    rdy_a = 1;
    tick();
    rdy_a = 0;
    wait_valid();
    chk("reseed_tvalid", va, 1);
    chk("reseed_tdata", da, 8'h01);
    chk("reseed_beat_count", bc_a, 0);
    chk("reseed_tlast", la, 0);
    chk("reseed_busy_clear", busy_a, 0);
    enable = 0;
    tick();
    chk("en_off_stall_tvalid", va, 1);
    chk("en_off_stall_tdata", da, 8'h01);
    rdy_a = 1;
    tick();
    chk("en_off_tvalid", va, 0);
    chk("en_off_beat_count", bc_a, 1);
    tick();
    chk("en_off_tvalid_hold", va, 0);
    enable = 1;
    tick();
    chk("en_on_tvalid", va, 1);
    chk("en_on_tdata", da, 8'h02);
    enable = 0;
    tick();
    chk("idle_again", va, 0);
    sv_a = 1; si_a = 8'h00; enable = 1;
    tick();
    sv_a = 0; rdy_a = 0;
    chk("zero_seed_tvalid", va, 1);
    chk("zero_seed_tdata", da, 8'h01);
    chk("zero_seed_count", bc_a, 0);
    chk("zero_seed_busy", busy_a, 0);
    sv_a = 1; si_a = 8'h55;
    tick();
    si_a = 8'hA5;
    tick();
    sv_a = 0;
    chk("last_wins_busy", busy_a, 1);
    chk("last_wins_stall", da, 8'h01);
    rdy_a = 1;
    tick();
    rdy_a = 0;
    wait_valid();
    chk("last_wins_tdata", da, 8'hA5);
    chk("last_wins_count", bc_a, 0);
    chk("steps8_first_tvalid", vc, 1);
    chk("steps8_first_tdata", dc, 8'hE1);
    mc = 16'hACE1;
    rdy_c = 1;
    tick();
    mc = fib16x8(mc);
    chk("steps8_second_tdata", dc, 8'hE4);
    for (int n = 0; n < 30; n++) begin
      tick();
      mc = fib16x8(mc);
      chk($sformatf("steps8_tdata_%0d", n), dc, mc[7:0]);
    end
    @(posedge clk);
    #2;
    resetn = 0;
    #1;
    chk("midrst_tvalid_a", va, 0);
    chk("midrst_tvalid_c", vc, 0);
    chk("midrst_beat_count", bc_c, 0);
    chk("midrst_tdata_c", dc, 8'hE1);
    chk("midrst_busy", busy_a, 0);
    #20;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
